// File: rtl/byteswap_arbiter.sv
// Two-requester, packet-granular round-robin arbiter feeding a shared byte-swap datapath.
// A single output register stage carries the winning beat and the requester index.
module byteswap_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            aclk,
  input  logic                            areset_n,

  input  logic                            s0_axis_tvalid,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                            s0_axis_tlast,

  input  logic                            s1_axis_tvalid,
  output logic                            s1_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                            s1_axis_tlast,

  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tid,

  output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt1
);

  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    m_valid_q, m_valid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KW-1:0]           m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic                    m_tid_q, m_tid_d;
  logic [C_CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [C_CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic out_free;
  logic acc0, acc1;

  // The output register can take a new beat if it is empty or is being drained this cycle.
  assign out_free       = !m_valid_q || m_axis_tready;
  assign s0_axis_tready = (state_q == GRANT0) && out_free;
  assign s1_axis_tready = (state_q == GRANT1) && out_free;
  assign acc0           = s0_axis_tvalid && s0_axis_tready;
  assign acc1           = s1_axis_tvalid && s1_axis_tready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && (!s1_axis_tvalid || !rr_q)) begin
          state_d = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (acc0 && s0_axis_tlast) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      GRANT1: begin
        if (acc1 && s1_axis_tlast) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_tid_d   = m_tid_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (acc0) begin
      m_valid_d = 1'b1;
      m_data_d  = s0_axis_tdata;
      m_keep_d  = s0_axis_tkeep;
      m_last_d  = s0_axis_tlast;
      m_tid_d   = 1'b0;
    end else if (acc1) begin
      m_valid_d = 1'b1;
      m_data_d  = s1_axis_tdata;
      m_keep_d  = s1_axis_tkeep;
      m_last_d  = s1_axis_tlast;
      m_tid_d   = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_keep_d  = '0;
      m_last_d  = 1'b0;
      m_tid_d   = 1'b0;
    end
    if (acc0 && s0_axis_tlast) begin
      cnt0_d = cnt0_q + C_CNT_WIDTH'(1);
    end
    if (acc1 && s1_axis_tlast) begin
      cnt1_d = cnt1_q + C_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_tid_q   <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_tid_q   <= m_tid_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_tid_q;
  assign pkt_cnt0      = cnt0_q;
  assign pkt_cnt1      = cnt1_q;

endmodule

// File: tb/tb_byteswap_arbiter.sv
// Self-checking bench for byteswap_arbiter: directed cycle checks, an arbitration
// vector table, and randomized traffic scored against per-requester packet queues.
module tb_byteswap_arbiter;
  localparam int W  = 32;
  localparam int KW = W / 8;
  localparam int CW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic pre_rr;
    logic v0;
    logic v1;
    logic rdy0;
    logic rdy1;
  } arb_vec_t;

  logic clk = 1'b0;
  logic areset_n;
  logic          sv[2];
  logic          tr[2];
  logic [W-1:0]  sd[2];
  logic [KW-1:0] sk[2];
  logic          sl[2];
  logic          m_tvalid, m_tready, m_tlast, m_tid;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  int    pkt_order[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  logic  sb_en    = 1'b0;
  logic  in_pkt   = 1'b0;
  logic  cur_tid  = 1'b0;
  logic  s1_done  = 1'b0;
  arb_vec_t vecs[8];

  always #5 clk = ~clk;

  byteswap_arbiter #(.C_AXIS_TDATA_WIDTH(W), .C_CNT_WIDTH(CW)) dut (
    .aclk(clk), .areset_n(areset_n),
    .s0_axis_tvalid(sv[0]), .s0_axis_tready(tr[0]), .s0_axis_tdata(sd[0]),
    .s0_axis_tkeep(sk[0]), .s0_axis_tlast(sl[0]),
    .s1_axis_tvalid(sv[1]), .s1_axis_tready(tr[1]), .s1_axis_tdata(sd[1]),
    .s1_axis_tkeep(sk[1]), .s1_axis_tlast(sl[1]),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_mlast"},  64'(m_tlast),  64'd0);
    chk({tag, "_mtid"},   64'(m_tid),    64'd0);
    chk({tag, "_mdata"},  64'(m_tdata),  64'd0);
    chk({tag, "_mkeep"},  64'(m_tkeep),  64'd0);
    chk({tag, "_rdy0"},   64'(tr[0]),    64'd0);
    chk({tag, "_rdy1"},   64'(tr[1]),    64'd0);
    chk({tag, "_cnt0"},   64'(pkt_cnt0), 64'd0);
    chk({tag, "_cnt1"},   64'(pkt_cnt1), 64'd0);
  endtask

  task automatic do_reset(input bit check_it);
    areset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sv[n] = 1'b0; sd[n] = '0; sk[n] = '0; sl[n] = 1'b0;
      src_q[n].delete();
      exp_q[n].delete();
    end
    pkt_order.delete();
    in_pkt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_it) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    @(posedge clk); #1;
    areset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic add_beat(input int n, input logic [W-1:0] d, input logic [KW-1:0] k,
                          input logic l, input int gap);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.gap = gap;
    src_q[n].push_back(b);
    exp_q[n].push_back(b);
  endtask

  // Presents queued beats on requester n, honouring per-beat idle gaps.
  task automatic send(input int n);
    beat_t b;
    int    to;
    while (src_q[n].size() > 0) begin
      b = src_q[n].pop_front();
      if (b.gap > 0) begin
        sv[n] = 1'b0;
        repeat (b.gap) begin @(posedge clk); #1; end
      end
      sv[n] = 1'b1; sd[n] = b.data; sk[n] = b.keep; sl[n] = b.last;
      to = 0;
      forever begin
        @(negedge clk);
        if (tr[n]) break;
        to++;
        if (to > 300) break;
      end
      if (to > 300) begin
        chk($sformatf("send%0d_timeout", n), 64'd1, 64'd0);
        src_q[n].delete();
      end
      @(posedge clk); #1;
    end
    sv[n] = 1'b0;
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(3) != 0);
      endcase
    end
  endtask

  // Scoreboard: each output beat must be the next expected beat of its requester.
  task automatic monitor();
    beat_t e;
    logic [W-1:0]  pd;
    logic [KW-1:0] pk;
    logic pl, pt, pv, pr;
    int t;
    pv = 1'b0; pr = 1'b1; pd = '0; pk = '0; pl = 1'b0; pt = 1'b0;
    forever begin
      @(negedge clk);
      if (areset_n) begin
        chk("tready_exclusive", 64'(tr[0] & tr[1]), 64'd0);
        if (pv && !pr) begin
          chk("hold_valid", 64'(m_tvalid), 64'd1);
          chk("hold_data",  64'(m_tdata),  64'(pd));
          chk("hold_keep",  64'(m_tkeep),  64'(pk));
          chk("hold_last",  64'(m_tlast),  64'(pl));
          chk("hold_tid",   64'(m_tid),    64'(pt));
        end
        if (sb_en && m_tvalid && m_tready) begin
          t = int'(m_tid);
          if (exp_q[t].size() == 0) begin
            chk($sformatf("extra_beat_tid%0d", t), 64'(m_tdata), 64'd0);
          end else begin
            e = exp_q[t].pop_front();
            chk("beat_data", 64'(m_tdata), 64'(e.data));
            chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
            chk("beat_last", 64'(m_tlast), 64'(e.last));
          end
          if (in_pkt) chk("packet_atomic_tid", 64'(m_tid), 64'(cur_tid));
          in_pkt  = !m_tlast;
          cur_tid = m_tid;
          if (m_tlast) pkt_order.push_back(t);
        end
      end
      pv = m_tvalid && areset_n; pr = m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast; pt = m_tid;
    end
  endtask

  initial begin
    int npk[2];
    int len;
    areset_n = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      sv[n] = 1'b0; sd[n] = '0; sk[n] = '0; sl[n] = 1'b0;
    end
    fork
      monitor();
      ready_gen();
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // {pre_rr, v0, v1, rdy0, rdy1}: grant decided from IDLE
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Single 4-beat packet, cycle-exact latency and throughput
    sb_en = 1'b0;
    do_reset(1);
    sv[0] = 1'b1; sd[0] = 32'h1; sk[0] = 4'hf; sl[0] = 1'b0;
    @(negedge clk);
    chk("single_rdy_t0", 64'(tr[0]), 64'd0);
    chk("single_mvalid_t0", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_rdy_t1", 64'(tr[0]), 64'd1);
    chk("single_mvalid_t1", 64'(m_tvalid), 64'd0);
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i <= 4) begin sd[0] = W'(i); sl[0] = (i == 4); end
      else sv[0] = 1'b0;
      @(negedge clk);
      chk($sformatf("single_mvalid_t%0d", i), 64'(m_tvalid), 64'd1);
      chk($sformatf("single_data_t%0d", i),   64'(m_tdata),  64'(i - 1));
      chk($sformatf("single_last_t%0d", i),   64'(m_tlast),  64'(i == 5));
      chk($sformatf("single_tid_t%0d", i),    64'(m_tid),    64'd0);
    end
    chk("single_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("single_rdy_idle", 64'(tr[0]), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_mvalid_drain", 64'(m_tvalid), 64'd0);

    // Arbitration table from IDLE, with and without the pointer advanced
    for (int v = 0; v < 8; v++) begin
      do_reset(0);
      if (vecs[v].pre_rr) begin
        sv[0] = 1'b1; sd[0] = 32'hee; sk[0] = 4'hf; sl[0] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
      end
      sv[0] = vecs[v].v0; sl[0] = 1'b1;
      sv[1] = vecs[v].v1; sl[1] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("arb_vec%0d_rdy0", v), 64'(tr[0]), 64'(vecs[v].rdy0));
      chk($sformatf("arb_vec%0d_rdy1", v), 64'(tr[1]), 64'(vecs[v].rdy1));
      sv[0] = 1'b0; sv[1] = 1'b0;
    end

    // Contention: alternating packet order
    do_reset(0);
    sb_en = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 2; n++)
        for (int b = 0; b < 2; b++)
          add_beat(n, W'(32'h100 * n + 16 * k + b), 4'hf, (b == 1), 0);
    fork send(0); send(1); join
    repeat (3) begin @(posedge clk); #1; end
    chk("contention_npkts", 64'(pkt_order.size()), 64'd6);
    for (int i = 0; i < pkt_order.size(); i++)
      chk($sformatf("contention_order%0d", i), 64'(pkt_order[i]), 64'(i % 2));
    chk("contention_cnt0", 64'(pkt_cnt0), 64'd3);
    chk("contention_cnt1", 64'(pkt_cnt1), 64'd3);

    // Backpressure mid-packet for 5 cycles
    do_reset(0);
    for (int b = 0; b < 4; b++) add_beat(0, W'(32'ha0 + b), 4'hf, (b == 3), 0);
    fork
      send(0);
      begin
        repeat (3) begin @(posedge clk); #1; end
        rdy_mode = 1;
        repeat (5) begin
          @(negedge clk);
          chk("bp_rdy0_low", 64'(tr[0]), 64'd0);
          chk("bp_mvalid_high", 64'(m_tvalid), 64'd1);
          @(posedge clk); #1;
        end
        rdy_mode = 0;
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_left0", 64'(exp_q[0].size()), 64'd0);
    chk("bp_cnt0", 64'(pkt_cnt0), 64'd1);

    // Gapped s1 packet while s0 waits
    do_reset(0);
    s1_done = 1'b0;
    for (int b = 0; b < 4; b++) add_beat(1, W'(32'hb0 + b), 4'h3, (b == 3), (b == 2) ? 3 : 0);
    for (int b = 0; b < 2; b++) add_beat(0, W'(32'hc0 + b), 4'hc, (b == 1), 0);
    fork
      begin send(1); s1_done = 1'b1; end
      begin @(posedge clk); #1; send(0); end
      begin
        for (int c = 0; c < 100 && !s1_done; c++) begin
          @(negedge clk);
          if (!s1_done) chk("gap_s0_rdy_low", 64'(tr[0]), 64'd0);
        end
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("gap_npkts", 64'(pkt_order.size()), 64'd2);
    if (pkt_order.size() == 2) begin
      chk("gap_first_tid", 64'(pkt_order[0]), 64'd1);
      chk("gap_second_tid", 64'(pkt_order[1]), 64'd0);
    end

    // Reset asserted after beat 2 of 4, then a clean packet
    do_reset(0);
    sb_en = 1'b0;
    sv[0] = 1'b1; sd[0] = 32'h11; sk[0] = 4'hf; sl[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; sd[0] = 32'h12;
    @(posedge clk); #1; sd[0] = 32'h13;
    chk("midrst_pre_mvalid", 64'(m_tvalid), 64'd1);
    areset_n = 1'b0;
    sv[0] = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    do_reset(0);
    sb_en = 1'b1;
    for (int b = 0; b < 3; b++) add_beat(0, W'(32'hd0 + b), 4'h5, (b == 2), 0);
    send(0);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_clean_left", 64'(exp_q[0].size()), 64'd0);
    chk("midrst_clean_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("midrst_clean_cnt1", 64'(pkt_cnt1), 64'd0);

    // Counter wrap with a 2-bit counter
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      add_beat(0, W'(32'he0 + 2 * i), 4'hf, 1'b0, 0);
      add_beat(0, W'(32'he1 + 2 * i), 4'h0, 1'b1, 0);
      send(0);
      @(negedge clk);
      chk($sformatf("wrap_cnt0_pkt%0d", i + 1), 64'(pkt_cnt0), 64'((i + 1) % (1 << CW)));
    end

    // Randomized traffic with random backpressure and input gaps
    do_reset(0);
    rdy_mode = 2;
    for (int n = 0; n < 2; n++) begin
      npk[n] = int'($urandom_range(8, 3));
      for (int p = 0; p < npk[n]; p++) begin
        len = int'($urandom_range(5, 1));
        for (int b = 0; b < len; b++)
          add_beat(n, $urandom, KW'($urandom_range(15)), (b == len - 1),
                   ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0);
      end
    end
    fork send(0); send(1); join
    rdy_mode = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rand_left0", 64'(exp_q[0].size()), 64'd0);
    chk("rand_left1", 64'(exp_q[1].size()), 64'd0);
    chk("rand_npkts", 64'(pkt_order.size()), 64'(npk[0] + npk[1]));
    chk("rand_cnt0", 64'(pkt_cnt0), 64'(npk[0] % (1 << CW)));
    chk("rand_cnt1", 64'(pkt_cnt1), 64'(npk[1] % (1 << CW)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
